// File: rtl/gen_controller.sv
// gen_controller: command sequencer for the PE array.
// Serialises clears, host cell accesses and generation steps.
module gen_controller #(
   parameter int N_X        = 64,
   parameter int N_Y        = 48,
   parameter int STATE_BITS = 1,
   parameter int CMD_BITS   = 2,
   parameter logic [CMD_BITS-1:0] CMD_NOP   = CMD_BITS'(0),
   parameter logic [CMD_BITS-1:0] CMD_WRITE = CMD_BITS'(1),
   parameter logic [CMD_BITS-1:0] CMD_READ  = CMD_BITS'(2),
   parameter logic [CMD_BITS-1:0] CMD_STEP  = CMD_BITS'(3),
   parameter int READ_LAT   = 1,
   parameter int STEP_WAIT  = 2,
   parameter int X_BITS     = $clog2(N_X),
   parameter int Y_BITS     = $clog2(N_Y)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick,
   input  logic                  run,
   input  logic                  clear_req,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [X_BITS-1:0]     host_x,
   input  logic [Y_BITS-1:0]     host_y,
   input  logic [STATE_BITS-1:0] host_wdata,
   output logic                  host_ack,
   output logic [STATE_BITS-1:0] host_rdata,
   output logic                  busy,
   output logic [15:0]           gen_count,
   output logic [X_BITS-1:0]     adr_x,
   output logic [Y_BITS-1:0]     adr_y,
   output logic [CMD_BITS-1:0]   opcode,
   output logic [STATE_BITS-1:0] vali,
   input  logic [STATE_BITS-1:0] valo
);

   localparam int LAT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam int WAIT_W = (STEP_WAIT > 1) ? $clog2(STEP_WAIT) : 1;

   // one extra bit so N_X / N_Y themselves are representable
   localparam logic [X_BITS:0] X_LIM = (X_BITS + 1)'(N_X);
   localparam logic [Y_BITS:0] Y_LIM = (Y_BITS + 1)'(N_Y);
   localparam logic [X_BITS-1:0] X_LAST = X_BITS'(N_X - 1);
   localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(N_Y - 1);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LAT - 1);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(STEP_WAIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_H_WR,
      S_H_RD,
      S_RD_WAIT,
      S_H_ACK,
      S_STEP,
      S_STEP_WAIT
   } state_t;

   state_t              state;
   logic                pend_tick;
   logic                pend_clr;
   logic [X_BITS-1:0]   cx;
   logic [Y_BITS-1:0]   cy;
   logic                clr_done;
   logic [LAT_W-1:0]    lat_cnt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                host_ok;

   // host address lies inside the array
   always_comb begin
      host_ok = ({1'b0, host_x} < X_LIM) && ({1'b0, host_y} < Y_LIM);
   end

   // sequencer: request flags, arbitration and the command stream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pend_tick  <= 1'b0;
         pend_clr   <= 1'b0;
         cx         <= '0;
         cy         <= '0;
         clr_done   <= 1'b0;
         lat_cnt    <= '0;
         wait_cnt   <= '0;
         host_ack   <= 1'b0;
         host_rdata <= '0;
         busy       <= 1'b0;
         gen_count  <= '0;
         adr_x      <= '0;
         adr_y      <= '0;
         opcode     <= CMD_NOP;
         vali       <= '0;
      end else begin
         opcode   <= CMD_NOP;
         host_ack <= 1'b0;
         if (clear_req) pend_clr <= 1'b1;
         if (tick && run) pend_tick <= 1'b1;

         unique case (state)
            S_IDLE: begin
               if (pend_clr) begin
                  state    <= S_CLEAR;
                  busy     <= 1'b1;
                  cx       <= '0;
                  cy       <= '0;
                  clr_done <= 1'b0;
               end else if (host_req) begin
                  busy <= 1'b1;
                  if (!host_ok) begin
                     // no array access; a failed read reads as zero
                     host_ack <= 1'b1;
                     if (!host_we) host_rdata <= '0;
                     state <= S_H_ACK;
                  end else if (host_we) begin
                     opcode <= CMD_WRITE;
                     adr_x  <= host_x;
                     adr_y  <= host_y;
                     vali   <= host_wdata;
                     state  <= S_H_WR;
                  end else begin
                     opcode  <= CMD_READ;
                     adr_x   <= host_x;
                     adr_y   <= host_y;
                     lat_cnt <= LAT_INIT;
                     state   <= S_H_RD;
                  end
               end else if (pend_tick) begin
                  opcode <= CMD_STEP;
                  busy   <= 1'b1;
                  state  <= S_STEP;
               end
            end

            S_CLEAR: begin
               if (clr_done) begin
                  gen_count <= '0;
                  pend_clr  <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  opcode <= CMD_WRITE;
                  adr_x  <= cx;
                  adr_y  <= cy;
                  vali   <= '0;
                  if (cx == X_LAST) begin
                     cx <= '0;
                     if (cy == Y_LAST) clr_done <= 1'b1;
                     else cy <= cy + Y_BITS'(1);
                  end else begin
                     cx <= cx + X_BITS'(1);
                  end
               end
            end

            S_H_WR: begin
               host_ack <= 1'b1;
               state    <= S_H_ACK;
            end

            S_H_RD, S_RD_WAIT: begin
               // adr stays put until valo is sampled
               if (lat_cnt == '0) begin
                  host_rdata <= valo;
                  host_ack   <= 1'b1;
                  state      <= S_H_ACK;
               end else begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
                  state   <= S_RD_WAIT;
               end
            end

            S_H_ACK: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            S_STEP: begin
               wait_cnt <= WAIT_INIT;
               state    <= S_STEP_WAIT;
            end

            S_STEP_WAIT: begin
               if (wait_cnt == '0) begin
                  gen_count <= gen_count + 16'd1;
                  pend_tick <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt - WAIT_W'(1);
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
